// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer arbiter: requester ids, default widths and the
// read-return tag carried down the return pipe.
package fb_pkg;

    localparam logic [1:0] REQ_RX    = 2'd0;
    localparam logic [1:0] REQ_SOBEL = 2'd1;
    localparam logic [1:0] REQ_TX    = 2'd2;
    localparam logic [1:0] REQ_NONE  = 2'd3;

    localparam int unsigned NUM_REQ   = 3;
    localparam int unsigned FB_ADDR_W = 15;
    localparam int unsigned FB_DATA_W = 8;
    localparam int unsigned FB_RD_LAT = 2;

    typedef struct packed {
        logic       valid;
        logic [1:0] id;
    } ret_tag_t;

    // Round-robin successor over the three requesters; REQ_NONE also maps to RX.
    function automatic logic [1:0] rr_next(input logic [1:0] cur);
        return (cur >= REQ_TX) ? REQ_RX : cur + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: pointer register plus combinational one-hot grant.
// Grants are suppressed while reset is asserted.
module rr_arbiter3
    import fb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] id
);

    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cand;
    logic       found;
    logic [3:0] req_m;
    logic [3:0] gnt_w;

    // Spare top bit keeps every candidate index in range, including REQ_NONE.
    assign req_m = {1'b0, req & {3{reset}}};
    assign gnt   = gnt_w[2:0];

    always_comb begin
        gnt_w = '0;
        id    = REQ_NONE;
        found = 1'b0;
        cand  = ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_m[cand]) begin
                found       = 1'b1;
                id          = cand;
                gnt_w[cand] = 1'b1;
            end
            cand = rr_next(cand);
        end
        ptr_d = found ? rr_next(id) : ptr_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= REQ_RX;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: one registered RAM command per clock, round-robin among RX,
// SOBEL and TX, with read data routed back to the issuer after a fixed latency.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W = FB_ADDR_W,
    parameter int unsigned DATA_W = FB_DATA_W,
    parameter int unsigned RD_LAT = FB_RD_LAT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_req,
    input  logic [ADDR_W-1:0] rx_addr,
    input  logic [DATA_W-1:0] rx_wdata,
    output logic              rx_gnt,
    input  logic              sb_req,
    input  logic              sb_we,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic [DATA_W-1:0] sb_wdata,
    output logic              sb_gnt,
    output logic              sb_rvalid,
    input  logic              tx_req,
    input  logic [ADDR_W-1:0] tx_addr,
    output logic              tx_gnt,
    output logic              tx_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_q,
    output logic [1:0]        db_owner
);

    logic [2:0]        req, gnt;
    logic [1:0]        win_id;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [1:0]        owner_q;
    logic [DATA_W-1:0] rdata_q;
    ret_tag_t          ret_in;
    ret_tag_t          ret_q [RD_LAT+1];

    assign req = {tx_req, sb_req, rx_req};

    rr_arbiter3 u_arb (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .gnt   (gnt),
        .id    (win_id)
    );

    assign rx_gnt  = gnt[REQ_RX];
    assign sb_gnt  = gnt[REQ_SOBEL];
    assign tx_gnt  = gnt[REQ_TX];
    assign any_gnt = |gnt;

    // Operand mux for the winner. RX only writes, TX only reads and carries no data.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = mem_addr_q;
        sel_wdata = mem_wdata_q;
        case (win_id)
            REQ_RX: begin
                sel_we    = 1'b1;
                sel_addr  = rx_addr;
                sel_wdata = rx_wdata;
            end
            REQ_SOBEL: begin
                sel_we    = sb_we;
                sel_addr  = sb_addr;
                sel_wdata = sb_wdata;
            end
            REQ_TX: begin
                sel_addr  = tx_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            owner_q     <= REQ_NONE;
        end else if (any_gnt) begin
            mem_addr_q  <= sel_addr;
            mem_we_q    <= sel_we;
            mem_wdata_q <= sel_wdata;
            owner_q     <= win_id;
        end else begin
            mem_we_q    <= 1'b0;
            owner_q     <= REQ_NONE;
        end
    end

    assign ret_in.valid = any_gnt & ~sel_we;
    assign ret_in.id    = win_id;

    // Stage 0 lines up with mem_addr; mem_q is captured as the tag leaves stage RD_LAT-1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i <= RD_LAT; i++) begin
                ret_q[i] <= '0;
            end
        end else begin
            ret_q[0] <= ret_in;
            for (int unsigned i = 1; i <= RD_LAT; i++) begin
                ret_q[i] <= ret_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (ret_q[RD_LAT-1].valid) begin
            rdata_q <= mem_q;
        end
    end

    assign sb_rvalid = ret_q[RD_LAT].valid && (ret_q[RD_LAT].id == REQ_SOBEL);
    assign tx_rvalid = ret_q[RD_LAT].valid && (ret_q[RD_LAT].id == REQ_TX);
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign db_owner  = owner_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed scenarios followed by randomized traffic,
// all compared against a transaction-level model of grants, RAM contents and read returns.
module tb_fb_arbiter;

    localparam int unsigned AW  = 15;
    localparam int unsigned DW  = 8;
    localparam int unsigned LAT = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          rx_req, sb_req, sb_we, tx_req;
    logic [AW-1:0] rx_addr, sb_addr, tx_addr, mem_addr;
    logic [DW-1:0] rx_wdata, sb_wdata, mem_wdata, mem_q, rdata;
    logic          rx_gnt, sb_gnt, tx_gnt, sb_rvalid, tx_rvalid, mem_we;
    logic [1:0]    db_owner;

    fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clock     (clock),
        .reset     (reset),
        .rx_req    (rx_req),
        .rx_addr   (rx_addr),
        .rx_wdata  (rx_wdata),
        .rx_gnt    (rx_gnt),
        .sb_req    (sb_req),
        .sb_we     (sb_we),
        .sb_addr   (sb_addr),
        .sb_wdata  (sb_wdata),
        .sb_gnt    (sb_gnt),
        .sb_rvalid (sb_rvalid),
        .tx_req    (tx_req),
        .tx_addr   (tx_addr),
        .tx_gnt    (tx_gnt),
        .tx_rvalid (tx_rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_q     (mem_q),
        .db_owner  (db_owner)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] init_val(input logic [14:0] a);
        if (a == 15'h100) return 8'h3C;
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
    endfunction

    // RAM environment: read-first, q registered once after the address (RD_LAT = 2).
    logic [7:0] ram [int];
    logic [7:0] ram_q;
    assign mem_q = ram_q;
    always @(posedge clock) begin
        ram_q <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : init_val(mem_addr);
        if (mem_we) ram[int'(mem_addr)] = mem_wdata;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester agents
    bit         op_pend [3];
    bit         op_we   [3];
    logic [14:0] op_addr [3];
    logic [7:0]  op_data [3];

    task automatic arm(input int i, input bit we, input int a, input int d);
        if (!op_pend[i]) begin
            op_pend[i] = 1'b1;
            op_we[i]   = (i == 0) ? 1'b1 : (i == 2) ? 1'b0 : we;
            op_addr[i] = 15'(a);
            op_data[i] = 8'(d);
        end
    endtask

    task automatic clear_ops();
        for (int i = 0; i < 3; i++) op_pend[i] = 1'b0;
    endtask

    task automatic drive();
        rx_req   = op_pend[0];
        rx_addr  = op_addr[0];
        rx_wdata = op_data[0];
        sb_req   = op_pend[1];
        sb_we    = op_we[1];
        sb_addr  = op_addr[1];
        sb_wdata = op_data[1];
        tx_req   = op_pend[2];
        tx_addr  = op_addr[2];
    endtask

    // Transaction-level model
    typedef struct {
        int due;
        int id;
        int data;
    } ret_t;

    logic [7:0] ref_mem [int];
    ret_t       ret_q [$];
    int         m_ptr = 0;
    int         cyc = 0;
    int         last_win = 3;
    int         e_we = 0, e_addr = 0, e_wdata = 0, e_owner = 3, e_rdata = 0;
    bit         rd_known = 1'b0;
    int         s_win, s_sbv, s_txv, s_rdata, s_we, s_addr, s_wdata, s_owner;

    function automatic int ref_rd(input int a);
        return ref_mem.exists(a) ? int'(ref_mem[a]) : int'(init_val(15'(a)));
    endfunction

    task automatic check_cycle();
        int win, exp_sb, exp_tx, c;
        bit ok_we, rd_req [3];
        s_win   = rx_gnt ? 0 : sb_gnt ? 1 : tx_gnt ? 2 : 3;
        s_sbv   = int'(sb_rvalid);
        s_txv   = int'(tx_rvalid);
        s_rdata = int'(rdata);
        s_we    = int'(mem_we);
        s_addr  = int'(mem_addr);
        s_wdata = int'(mem_wdata);
        s_owner = int'(db_owner);
        chk("gnt_count", int'(rx_gnt) + int'(sb_gnt) + int'(tx_gnt), (s_win == 3) ? 0 : 1);
        if (!reset) begin
            chk("rst_gnt", s_win, 3);
            chk("rst_we", s_we, 0);
            chk("rst_addr", s_addr, 0);
            chk("rst_wdata", s_wdata, 0);
            chk("rst_owner", s_owner, 3);
            chk("rst_rvalid", s_sbv + s_txv, 0);
            m_ptr = 0; ret_q.delete();
            e_we = 0; e_addr = 0; e_wdata = 0; e_owner = 3;
            rd_known = 1'b0; last_win = 3; cyc++;
            return;
        end
        chk("mem_we", s_we, e_we);
        chk("mem_addr", s_addr, e_addr);
        if (e_we != 0) chk("mem_wdata", s_wdata, e_wdata);
        chk("db_owner", s_owner, e_owner);
        exp_sb = 0; exp_tx = 0;
        if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            ret_t r = ret_q.pop_front();
            if (r.id == 1) exp_sb = 1; else exp_tx = 1;
            e_rdata = r.data; rd_known = 1'b1;
        end
        chk("sb_rvalid", s_sbv, exp_sb);
        chk("tx_rvalid", s_txv, exp_tx);
        if (rd_known) chk("rdata", s_rdata, e_rdata);
        rd_req[0] = op_pend[0]; rd_req[1] = op_pend[1]; rd_req[2] = op_pend[2];
        win = 3;
        for (int k = 0; k < 3; k++) begin
            c = (m_ptr + k) % 3;
            if (win == 3 && rd_req[c]) win = c;
        end
        chk("grant", s_win, win);
        last_win = win;
        if (win != 3) begin
            ok_we   = op_we[win];
            m_ptr   = (win + 1) % 3;
            e_we    = int'(ok_we);
            e_addr  = int'(op_addr[win]);
            e_owner = win;
            if (ok_we) begin
                e_wdata = int'(op_data[win]);
                ref_mem[e_addr] = op_data[win];
            end else begin
                ret_q.push_back('{cyc + 1 + int'(LAT), win, ref_rd(e_addr)});
            end
        end else begin
            e_we = 0; e_owner = 3;
        end
        cyc++;
    endtask

    task automatic tick();
        drive();
        @(negedge clock);
        check_cycle();
        @(posedge clock);
        #1;
        if (last_win < 3) op_pend[last_win] = 1'b0;
        drive();
    endtask

    initial begin
        clear_ops();
        for (int i = 0; i < 3; i++) begin
            op_we[i] = 1'b0; op_addr[i] = '0; op_data[i] = '0;
        end
        reset = 1'b1;
        drive();
        #1 reset = 1'b0;

        // 1: reset with every request high
        arm(0, 1, 'h11, 'h01); arm(1, 1, 'h12, 'h02); arm(2, 0, 'h13, 0);
        tick();
        chk("t1_no_gnt", s_win, 3);
        chk("t1_owner", s_owner, 3);
        chk("t1_we", s_we, 0);
        clear_ops();
        reset = 1'b1;

        // 2: single RX write
        arm(0, 1, 'h0010, 'hA5);
        tick();
        chk("t2_rx_gnt", s_win, 0);
        tick();
        chk("t2_we", s_we, 1);
        chk("t2_addr", s_addr, 'h0010);
        chk("t2_wdata", s_wdata, 'hA5);
        chk("t2_no_rv", s_sbv + s_txv, 0);

        // 3: all three requesting for six cycles
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            arm(0, 1, 'h20 + k, 'h30 + k);
            arm(1, 1, 'h40 + k, 'h50 + k);
            arm(2, 0, 'h60 + k, 0);
            tick();
            chk("t3_order", s_win, k % 3);
            if (k > 0) chk("t3_owner_lag", s_owner, (k - 1) % 3);
        end
        clear_ops();
        repeat (4) tick();

        // 4: SOBEL read returning 0x3C
        arm(1, 0, 'h0100, 0);
        tick();
        chk("t4_gnt", s_win, 1);
        tick();
        chk("t4_early1", s_sbv, 0);
        tick();
        chk("t4_early2", s_sbv, 0);
        tick();
        chk("t4_sbv", s_sbv, 1);
        chk("t4_rdata", s_rdata, 'h3C);
        chk("t4_txv", s_txv, 0);
        tick();
        chk("t4_one_shot", s_sbv, 0);
        chk("t4_hold", s_rdata, 'h3C);

        // 5: TX read then SOBEL read on consecutive cycles
        arm(2, 0, 'h0200, 0);
        tick();
        chk("t5_tx_gnt", s_win, 2);
        arm(1, 0, 'h0201, 0);
        tick();
        chk("t5_sb_gnt", s_win, 1);
        tick();
        tick();
        chk("t5_txv", s_txv, 1);
        chk("t5_tx_data", s_rdata, int'(init_val(15'h0200)));
        tick();
        chk("t5_sbv", s_sbv, 1);
        chk("t5_sb_data", s_rdata, int'(init_val(15'h0201)));

        // 6: reset while a read is in flight
        arm(1, 0, 'h0300, 0);
        tick();
        chk("t6_gnt", s_win, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t6_no_rv", s_sbv + s_txv, 0);
        end
        arm(0, 1, 'h0301, 'h77); arm(1, 1, 'h0302, 'h78); arm(2, 0, 'h0303, 0);
        tick();
        chk("t6_ptr_rx", s_win, 0);
        clear_ops();
        repeat (4) tick();

        // Randomized traffic over a small address window to force same-address hazards
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!op_pend[i] && ($urandom % 100) < 45) begin
                    arm(i, 1'($urandom), 'h400 + int'($urandom_range(0, 15)), int'($urandom % 256));
                end
            end
            reset = (n == 1500) ? 1'b0 : 1'b1;
            tick();
        end
        reset = 1'b1;
        clear_ops();
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
